// File: rtl/ahb_mem_slave.sv
// AHB slave front end for a synchronous single-port 32-bit memory with wait states and ERROR responses.
// Define AHB_SLV_ALIGN_CHK_EN to reject misaligned half/word transfers with an ERROR response.
module ahb_mem_slave #(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS   = 8192,
  parameter int REGION_BITS = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [31:0]                  HWDATA,
  input  logic                         HREADY,
  output logic [31:0]                  HRDATA,
  output logic                         HREADYOUT,
  output logic [1:0]                   HRESP,
  output logic                         MEM_enable,
  output logic                         MEM_write,
  output logic [3:0]                   MEM_wstrb,
  output logic [$clog2(MEM_WORDS)-1:0] MEM_address,
  output logic [31:0]                  MEM_wdata,
  input  logic [31:0]                  MEM_rdata,
  output logic [2:0]                   dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [REGION_BITS:0] MEM_BYTES = (REGION_BITS+1)'(MEM_WORDS * 4);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DATA  = 3'd3,
    S_WR       = 3'd4,
    S_ERR1     = 3'd5,
    S_ERR2     = 3'd6
  } state_t;

  // Handshake: an address phase is taken only when HSEL, HREADY and HTRANS[1] are all high;
  // HREADYOUT low stretches the current data phase and the master holds HWDATA meanwhile.
  state_t        state, state_nxt, accept_state;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic [3:0]    cnt_q, cnt_nxt;
  logic          accept, misalign, err, load;
  logic [3:0]    lane_strb;
  logic          unused_bits;

  assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SLV_ALIGN_CHK_EN
  assign misalign = ((HSIZE == 3'd1) & HADDR[0]) |
                    ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err = (HSIZE > 3'd2) | ({1'b0, HADDR[REGION_BITS-1:0]} >= MEM_BYTES) | misalign;

  assign unused_bits = ^{HTRANS[0], HADDR[31:REGION_BITS]};

  // Where a newly accepted address phase leads; shared by every state that ends a data phase.
  always_comb begin
    accept_state = S_IDLE;
    if (accept) begin
      if (err)                  accept_state = S_ERR1;
      else if (WAIT_STATES > 0) accept_state = S_WAIT;
      else if (HWRITE)          accept_state = S_WR;
      else                      accept_state = S_RD_ISSUE;
    end
  end

  // Low address bits are not cleared, so a misaligned half lands on its containing half-word.
  always_comb begin
    case (size_q)
      2'd0:    lane_strb = 4'b0001 << addr_q[1:0];
      2'd1:    lane_strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_q;
    load       = 1'b0;
    HREADYOUT  = 1'b1;
    HRESP      = 2'b00;
    HRDATA     = '0;
    MEM_enable = 1'b0;
    MEM_write  = 1'b0;
    MEM_wstrb  = '0;
    case (state)
      S_IDLE: begin
        state_nxt = accept_state;
        load      = accept;
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 4'd0) state_nxt = write_q ? S_WR : S_RD_ISSUE;
        else               cnt_nxt   = cnt_q - 4'd1;
      end
      S_RD_ISSUE: begin
        HREADYOUT  = 1'b0;
        MEM_enable = 1'b1;
        state_nxt  = S_RD_DATA;
      end
      S_RD_DATA: begin
        HRDATA    = MEM_rdata;
        state_nxt = accept_state;
        load      = accept;
      end
      S_WR: begin
        MEM_enable = 1'b1;
        MEM_write  = 1'b1;
        MEM_wstrb  = lane_strb;
        state_nxt  = accept_state;
        load       = accept;
      end
      S_ERR1: begin
        HRESP     = 2'b01;
        HREADYOUT = 1'b0;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        HRESP     = 2'b01;
        state_nxt = accept_state;
        load      = accept;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
        cnt_q   <= WAIT_LOAD;
      end else begin
        cnt_q <= cnt_nxt;
      end
    end
  end

  assign MEM_address = addr_q[AW+1:2];
  assign MEM_wdata   = HWDATA;
  assign dbg_state   = state;

endmodule
